// File: rtl/pmem_responder.sv
// pmem_responder: line-oriented physical-memory model for an LC-3b style
// cache. Accepts one read or write of a 128-bit line at a time, answers
// after a fixed LATENCY with a single-cycle pmem_resp pulse, and latches
// any initiator protocol violation in a sticky proto_err flag.
module pmem_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         busy,
    output logic         proto_err
);

    localparam int         LINES  = 1 << INDEX_BITS;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    is_wr_q, is_wr_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [15:0]             addr_q, addr_d;
    logic [127:0]            wdata_q, wdata_d;
    logic [127:0]            rdata_q, rdata_d;
    logic                    resp_q, resp_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [127:0]            mem_q [LINES];
    logic [127:0]            mem_d [LINES];

    logic [INDEX_BITS-1:0]   req_idx_s;
    logic                    held_req_s;

    // Line index of the incoming address; offset and high bits alias away.
    assign req_idx_s = pmem_address[INDEX_BITS+3:4];

    // The captured operation's own request line must stay high while busy.
    assign held_req_s = is_wr_q ? pmem_write : pmem_read;

    // Next-state, capture, read-data, array-update and flag logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_d   = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (pmem_read || pmem_write) begin
                    // A simultaneous read+write is resolved as a write.
                    is_wr_d = pmem_write;
                    idx_d   = req_idx_s;
                    addr_d  = pmem_address;
                    wdata_d = pmem_wdata;
                    cnt_d   = LAT_M1;
                    if (pmem_read && pmem_write) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        if (!pmem_write) begin
                            rdata_d = mem_q[req_idx_s];
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Inputs are not acted on here, only watched for violations.
                if (!held_req_s || (pmem_address != addr_q)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    // Earlier writes committed before this accept, so no stale data.
                    if (!is_wr_q) begin
                        rdata_d = mem_q[idx_q];
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (is_wr_q) begin
                    mem_d[idx_q] = wdata_q;
                end else begin
                    mem_d = mem_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        resp_d = (state_d == ST_RESP);
        busy_d = (state_d != ST_IDLE);
    end

    // State, capture registers, registered outputs and backing store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            addr_q  <= 16'd0;
            wdata_q <= 128'd0;
            rdata_q <= 128'd0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign pmem_resp  = resp_q;
    assign pmem_rdata = rdata_q;
    assign busy       = busy_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Testbench for pmem_responder: one instance at LATENCY=4 and one at
// LATENCY=1, both INDEX_BITS=4. Directed table, hand-written corner
// sequences and random traffic checked against a line-array model.
module tb_pmem_responder;

    logic              clk;
    logic              rst_n;
    logic [1:0]        rd, wr;
    logic [1:0][15:0]  addr;
    logic [1:0][127:0] wd;
    logic [1:0]        resp, busy, err;
    logic [1:0][127:0] rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: per-instance line array, last read data, sticky error.
    logic [127:0] mdl_mem   [2][16];
    logic [127:0] mdl_rdata [2];
    logic         mdl_err   [2];

    typedef struct {
        logic         trd;
        logic         twr;
        logic [15:0]  taddr;
        logic [127:0] twd;
        logic [127:0] exp_rdata;
        logic         exp_err;
    } vec_t;

    vec_t vecs [6];

    pmem_responder #(.LATENCY(4), .INDEX_BITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(addr[0]), .pmem_wdata(wd[0]),
        .pmem_resp(resp[0]), .pmem_rdata(rdata[0]),
        .busy(busy[0]), .proto_err(err[0])
    );

    pmem_responder #(.LATENCY(1), .INDEX_BITS(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(addr[1]), .pmem_wdata(wd[1]),
        .pmem_resp(resp[1]), .pmem_rdata(rdata[1]),
        .busy(busy[1]), .proto_err(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int l = 0; l < 16; l++) mdl_mem[s][l] = 128'd0;
            mdl_rdata[s] = 128'd0;
            mdl_err[s]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd = 2'b00;
        wr = 2'b00;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_resp", resp[s], 1'b0);
            chk("rst_busy", busy[s], 1'b0);
            chk("rst_err", err[s], 1'b0);
            chk("rst_rdata", rdata[s], 128'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One complete transaction on instance sel; optionally the initiator
    // misbehaves in the first busy cycle (drops request, moves address/data).
    task automatic txn(input int sel, input logic trd, input logic twr,
                       input logic [15:0] taddr, input logic [127:0] twd,
                       input bit drop, output logic [127:0] got_rd,
                       output logic got_err, output int got_cyc);
        int lat;
        int idx;
        lat = (sel == 0) ? 4 : 1;
        if (lat == 1) drop = 1'b0;
        idx = (int'(taddr) / 16) % 16;
        if (twr) begin
            if (trd) mdl_err[sel] = 1'b1;
        end else begin
            mdl_rdata[sel] = mdl_mem[sel][idx];
        end
        if (drop) mdl_err[sel] = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy[sel], 1'b0);
        chk("idle_resp", resp[sel], 1'b0);
        rd[sel]   = trd;
        wr[sel]   = twr;
        addr[sel] = taddr;
        wd[sel]   = twd;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (drop && k == 1) begin
                rd[sel]   = 1'b0;
                wr[sel]   = 1'b0;
                addr[sel] = taddr ^ 16'h0010;
                wd[sel]   = ~twd;
            end
            chk("resp_timing", resp[sel], (k == lat));
            chk("busy_level", busy[sel], 1'b1);
        end
        got_rd  = rdata[sel];
        got_err = err[sel];
        got_cyc = cyc;
        chk("rdata", rdata[sel], mdl_rdata[sel]);
        chk("proto_err", err[sel], mdl_err[sel]);
        rd[sel] = 1'b0;
        wr[sel] = 1'b0;
        if (twr) mdl_mem[sel][idx] = twd;
    endtask

    initial begin
        logic [127:0] g_rd;
        logic         g_err;
        int           g_cyc;
        int           c_a;
        logic [127:0] d1;
        logic [127:0] daa;
        logic [127:0] dc1;
        int           r;
        int           s;
        logic         t_rd, t_wr;
        logic [15:0]  t_addr;
        bit           t_drop;

        d1  = 128'h0123456789ABCDEF0123456789ABCDEF;
        daa = {16{8'hAA}};
        dc1 = 128'hC0FFEE00112233445566778899AABBCC;
        vecs[0] = '{1'b0, 1'b1, 16'h0010, d1,         128'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0010, 128'd0,     d1,     1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h0100, daa,        d1,     1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0000, 128'd0,     daa,    1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h0030, dc1,        daa,    1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0030, 128'd0,     dc1,    1'b1};

        rst_n = 1'b0;
        rd    = 2'b00;
        wr    = 2'b00;
        addr  = '0;
        wd    = '0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset();

        // Directed table on the LATENCY=4 instance.
        for (int v = 0; v < 6; v++) begin
            txn(0, vecs[v].trd, vecs[v].twr, vecs[v].taddr, vecs[v].twd, 1'b0, g_rd, g_err, g_cyc);
            chk("tbl_rdata", g_rd, vecs[v].exp_rdata);
            chk("tbl_err", g_err, vecs[v].exp_err);
        end
        // Error flag is sticky across idle cycles.
        repeat (3) @(negedge clk);
        chk("err_sticky", err[0], 1'b1);

        // Request dropped and address moved during BUSY.
        do_reset();
        txn(0, 1'b0, 1'b1, 16'h0070, d1, 1'b0, g_rd, g_err, g_cyc);
        txn(0, 1'b1, 1'b0, 16'h0070, 128'd0, 1'b1, g_rd, g_err, g_cyc);
        chk("drop_rdata", g_rd, d1);
        chk("drop_err", g_err, 1'b1);

        // Reset two cycles into a write: no pulse, nothing committed.
        do_reset();
        @(negedge clk);
        wr[0]   = 1'b1;
        addr[0] = 16'h0040;
        wd[0]   = d1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        wr[0] = 1'b0;
        #1;
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_resp", resp[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_noresp", resp[0], 1'b0);
        end
        txn(0, 1'b1, 1'b0, 16'h0040, 128'd0, 1'b0, g_rd, g_err, g_cyc);
        chk("midrst_read0", g_rd, 128'd0);

        // LATENCY=1 back-to-back reads, then write/read of the same line.
        do_reset();
        txn(1, 1'b1, 1'b0, 16'h0000, 128'd0, 1'b0, g_rd, g_err, c_a);
        chk("l1_rd0", g_rd, 128'd0);
        txn(1, 1'b1, 1'b0, 16'h0020, 128'd0, 1'b0, g_rd, g_err, g_cyc);
        chk("l1_rd1", g_rd, 128'd0);
        chk("l1_spacing", 128'(g_cyc - c_a), 128'd2);
        txn(1, 1'b0, 1'b1, 16'h0050, dc1, 1'b0, g_rd, g_err, g_cyc);
        txn(1, 1'b1, 1'b0, 16'h0050, 128'd0, 1'b0, g_rd, g_err, g_cyc);
        chk("l1_nostale", g_rd, dc1);

        // Random traffic on both instances.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            s = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 19));
            t_rd   = (r < 10) || (r == 19);
            t_wr   = (r >= 10);
            t_addr = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            t_drop = (s == 0) && ($urandom_range(0, 14) == 0);
            txn(s, t_rd, t_wr, t_addr, {$urandom, $urandom, $urandom, $urandom},
                t_drop, g_rd, g_err, g_cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
